// File: rtl/cve2_rf_wr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cve2_rf_wr_arbiter_if: core writeback, coprocessor result and RF write bus  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface cve2_rf_wr_arbiter_if;
  logic [4:0]  rf_waddr_id_i;
  logic [31:0] rf_wdata_id_i;
  logic        rf_we_id_i;
  logic [31:0] rf_wdata_lsu_i;
  logic        rf_we_lsu_i;
  logic        xif_result_valid_i;
  logic        xif_result_ready_o;
  logic [4:0]  xif_result_rd_i;
  logic [31:0] xif_result_data_i;
  logic        xif_result_we_i;
  logic        flush_i;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic        rf_we_wb_o;
  logic        stall_id_o;
  logic        xif_pending_o;
  logic        collision_err_o;

  modport slave (
    input  rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i, rf_wdata_lsu_i, rf_we_lsu_i,
    input  xif_result_valid_i, xif_result_rd_i, xif_result_data_i, xif_result_we_i, flush_i,
    output xif_result_ready_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
    output stall_id_o, xif_pending_o, collision_err_o
  );

  modport master (
    output rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i, rf_wdata_lsu_i, rf_we_lsu_i,
    output xif_result_valid_i, xif_result_rd_i, xif_result_data_i, xif_result_we_i, flush_i,
    input  xif_result_ready_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
    input  stall_id_o, xif_pending_o, collision_err_o
  );
endinterface
`default_nettype wire

// File: rtl/cve2_rf_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cve2_rf_wr_arbiter: shares the RF write port between core and coprocessor  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cve2_rf_wr_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cve2_rf_wr_arbiter_if.slave  bus
);
  localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned c_STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
  localparam logic [c_STV_W-1:0] c_LIMIT = c_STV_W'(STARVE_LIMIT);

  logic [4:0]         r_mem_rd   [DEPTH];
  logic [31:0]        r_mem_data [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_STV_W-1:0] r_starve;
  logic               r_collision;

  logic w_core_we;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_store;
  logic w_pop;

  assign w_core_we = bus.rf_we_id_i | bus.rf_we_lsu_i;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_DEPTH);
  assign w_push    = bus.xif_result_valid_i & ~w_full & ~bus.flush_i;
  // Non-writing results and writes to x0 complete the handshake but are not buffered.
  assign w_store   = w_push & bus.xif_result_we_i & (bus.xif_result_rd_i != 5'd0);
  // Gating with rst_ni keeps entries buffered before a reset from ever reaching the RF.
  assign w_pop     = ~w_empty & ~w_core_we & ~bus.flush_i & rst_ni;

  assign bus.xif_result_ready_o = ~w_full;
  assign bus.xif_pending_o      = ~w_empty;
  assign bus.stall_id_o         = (r_starve == c_LIMIT);
  assign bus.collision_err_o    = r_collision;

  always_comb begin
    bus.rf_we_wb_o    = 1'b0;
    bus.rf_waddr_wb_o = 5'd0;
    bus.rf_wdata_wb_o = 32'd0;
    if (w_core_we) begin
      bus.rf_we_wb_o    = 1'b1;
      bus.rf_waddr_wb_o = bus.rf_waddr_id_i;
      bus.rf_wdata_wb_o = (bus.rf_wdata_id_i  & {32{bus.rf_we_id_i}})
                        | (bus.rf_wdata_lsu_i & {32{bus.rf_we_lsu_i}});
    end else if (w_pop) begin
      bus.rf_we_wb_o    = 1'b1;
      bus.rf_waddr_wb_o = r_mem_rd[r_rd_ptr];
      bus.rf_wdata_wb_o = r_mem_data[r_rd_ptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store) begin
      r_mem_rd[r_wr_ptr]   <= bus.xif_result_rd_i;
      r_mem_data[r_wr_ptr] <= bus.xif_result_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_starve <= '0;
    end else if (w_pop || bus.flush_i || w_empty) begin
      r_starve <= '0;
    end else if (r_starve != c_LIMIT) begin
      r_starve <= r_starve + c_STV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_collision <= 1'b0;
    end else if (bus.rf_we_id_i && bus.rf_we_lsu_i) begin
      r_collision <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cve2_rf_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cve2_rf_wr_arbiter: directed self-checking bench for the RF arbiter     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cve2_rf_wr_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cve2_rf_wr_arbiter_if u_if ();

  cve2_rf_wr_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic core(input logic we_id, input logic we_lsu, input logic [4:0] a,
                      input logic [31:0] d_id, input logic [31:0] d_lsu);
    u_if.rf_we_id_i     = we_id;
    u_if.rf_we_lsu_i    = we_lsu;
    u_if.rf_waddr_id_i  = a;
    u_if.rf_wdata_id_i  = d_id;
    u_if.rf_wdata_lsu_i = d_lsu;
  endtask

  task automatic xif(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
    u_if.xif_result_valid_i = v;
    u_if.xif_result_we_i    = we;
    u_if.xif_result_rd_i    = rd;
    u_if.xif_result_data_i  = d;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"},    32'(u_if.rf_we_wb_o),    32'(we));
    chk({tag, "_waddr"}, 32'(u_if.rf_waddr_wb_o), 32'(a));
    chk({tag, "_wdata"}, u_if.rf_wdata_wb_o,      d);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    core(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    xif(1'b0, 1'b0, 5'd0, 32'd0);
    u_if.flush_i = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_ready",   32'(u_if.xif_result_ready_o), 32'd1);
    chk("rst_pending", 32'(u_if.xif_pending_o),      32'd0);
    chk("rst_stall",   32'(u_if.stall_id_o),         32'd0);
    chk("rst_coll",    32'(u_if.collision_err_o),    32'd0);
    chk_wb("rst", 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1 core only, inactive LSU data must be masked
    core(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'hFFFF0000);
    #1;
    chk_wb("t1_id", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("t1_pending", 32'(u_if.xif_pending_o), 32'd0);
    core(1'b0, 1'b1, 5'd9, 32'h00001111, 32'hCAFE0000);
    #1;
    chk_wb("t1_lsu", 1'b1, 5'd9, 32'hCAFE0000);
    tick();
    core(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    // T2 coprocessor result in an idle cycle
    xif(1'b1, 1'b1, 5'd7, 32'h00001234);
    #1;
    chk("t2_ready", 32'(u_if.xif_result_ready_o), 32'd1);
    chk("t2_nowr",  32'(u_if.rf_we_wb_o),         32'd0);
    tick();
    xif(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("t2_pending1", 32'(u_if.xif_pending_o), 32'd1);
    chk_wb("t2_pop", 1'b1, 5'd7, 32'h00001234);
    tick();
    chk("t2_pending0", 32'(u_if.xif_pending_o), 32'd0);
    chk_wb("t2_idle", 1'b0, 5'd0, 32'd0);

    // Simultaneous push and pop
    xif(1'b1, 1'b1, 5'd20, 32'h00000020);
    tick();
    xif(1'b1, 1'b1, 5'd21, 32'h00000021);
    #1;
    chk_wb("pp_pop0", 1'b1, 5'd20, 32'h00000020);
    tick();
    xif(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("pp_pending", 32'(u_if.xif_pending_o), 32'd1);
    chk_wb("pp_pop1", 1'b1, 5'd21, 32'h00000021);
    tick();
    chk("pp_empty", 32'(u_if.xif_pending_o), 32'd0);

    // T3 fill with core busy, then backpressure and in-order drain
    core(1'b1, 1'b0, 5'd3, 32'h0000AAAA, 32'd0);
    xif(1'b1, 1'b1, 5'd10, 32'h000000A0);
    tick();
    xif(1'b1, 1'b1, 5'd11, 32'h000000B0);
    tick();
    xif(1'b1, 1'b1, 5'd12, 32'h000000C0);
    #1;
    chk("t3_ready0", 32'(u_if.xif_result_ready_o), 32'd0);
    chk_wb("t3_core", 1'b1, 5'd3, 32'h0000AAAA);
    tick();
    xif(1'b0, 1'b0, 5'd0, 32'd0);
    core(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("t3_ready_pop", 32'(u_if.xif_result_ready_o), 32'd0);
    chk_wb("t3_pop0", 1'b1, 5'd10, 32'h000000A0);
    tick();
    chk("t3_ready1", 32'(u_if.xif_result_ready_o), 32'd1);
    chk_wb("t3_pop1", 1'b1, 5'd11, 32'h000000B0);
    tick();
    chk("t3_empty", 32'(u_if.xif_pending_o), 32'd0);
    chk_wb("t3_idle", 1'b0, 5'd0, 32'd0);

    // T4 starvation
    core(1'b1, 1'b0, 5'd1, 32'h00000001, 32'd0);
    xif(1'b1, 1'b1, 5'd4, 32'h00000044);
    tick();
    xif(1'b0, 1'b0, 5'd0, 32'd0);
    chk("t4_stall_e0", 32'(u_if.stall_id_o), 32'd0);
    tick();
    tick();
    tick();
    chk("t4_stall_e3", 32'(u_if.stall_id_o), 32'd0);
    tick();
    chk("t4_stall_e4", 32'(u_if.stall_id_o), 32'd1);
    core(1'b0, 1'b1, 5'd1, 32'd0, 32'h00000055);
    #1;
    chk_wb("t4_lsu", 1'b1, 5'd1, 32'h00000055);
    tick();
    chk("t4_stall_sat", 32'(u_if.stall_id_o), 32'd1);
    core(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk_wb("t4_pop", 1'b1, 5'd4, 32'h00000044);
    tick();
    chk("t4_stall_clr", 32'(u_if.stall_id_o),    32'd0);
    chk("t4_empty",     32'(u_if.xif_pending_o), 32'd0);

    // T5 discarded results and flush
    xif(1'b1, 1'b1, 5'd0, 32'h00000099);
    #1;
    chk("t5_rd0_ready", 32'(u_if.xif_result_ready_o), 32'd1);
    tick();
    xif(1'b1, 1'b0, 5'd8, 32'h00000088);
    #1;
    chk("t5_rd0_pend", 32'(u_if.xif_pending_o), 32'd0);
    tick();
    xif(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("t5_nowe_pend", 32'(u_if.xif_pending_o), 32'd0);
    chk_wb("t5_idle", 1'b0, 5'd0, 32'd0);
    core(1'b1, 1'b0, 5'd2, 32'h00000002, 32'd0);
    xif(1'b1, 1'b1, 5'd13, 32'h0000000D);
    tick();
    xif(1'b1, 1'b1, 5'd14, 32'h0000000E);
    tick();
    xif(1'b0, 1'b0, 5'd0, 32'd0);
    core(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    u_if.flush_i = 1'b1;
    #1;
    chk("t5_full", 32'(u_if.xif_pending_o), 32'd1);
    chk_wb("t5_flush", 1'b0, 5'd0, 32'd0);
    tick();
    u_if.flush_i = 1'b0;
    #1;
    chk("t5_flushed", 32'(u_if.xif_pending_o),      32'd0);
    chk("t5_ready",   32'(u_if.xif_result_ready_o), 32'd1);
    chk_wb("t5_after", 1'b0, 5'd0, 32'd0);

    // T6 collision, then reset with an entry buffered
    core(1'b1, 1'b1, 5'd2, 32'h000000F0, 32'h00000F00);
    #1;
    chk_wb("t6_or", 1'b1, 5'd2, 32'h00000FF0);
    chk("t6_coll_pre", 32'(u_if.collision_err_o), 32'd0);
    tick();
    core(1'b1, 1'b0, 5'd6, 32'h00000006, 32'd0);
    xif(1'b1, 1'b1, 5'd30, 32'h00000030);
    #1;
    chk("t6_coll1", 32'(u_if.collision_err_o), 32'd1);
    tick();
    xif(1'b0, 1'b0, 5'd0, 32'd0);
    core(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    chk("t6_coll_hold", 32'(u_if.collision_err_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_wb("t6_rst_nowr", 1'b0, 5'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_coll_rst", 32'(u_if.collision_err_o), 32'd0);
    chk("t6_pend_rst", 32'(u_if.xif_pending_o),   32'd0);
    chk_wb("t6_after", 1'b0, 5'd0, 32'd0);
    tick();
    chk("t6_still_empty", 32'(u_if.xif_pending_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
